// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and mode constants.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_cell.sv
// One-bit combinational add/subtract cell; cout is carry-out in add mode, borrow-out in sub mode.
module full_add_sub_cell
  import serial_add_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout
);

  always_comb begin
    s = x ^ y ^ cin;
    if (mode == MODE_SUB) cout = (~x & y) | (cin & ~(x ^ y));
    else                  cout = (x & y) | (cin & (x ^ y));
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial unsigned adder/subtractor: one bit per clock, LSB first, single cell with registered carry/borrow.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, work;
  logic             mode_q, cy_q;
  logic [CW-1:0]    cnt;
  logic             load, step, last;
  logic             bit_s, bit_c;

  full_add_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (cy_q),
    .mode (mode_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == ST_RUN);
      done  <= (state_d == ST_DONE);
    end
  end

  // Serial datapath; result/carry update only on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      mode_q <= MODE_ADD;
      cy_q   <= 1'b0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      mode_q <= mode;
      cy_q   <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      work <= {bit_s, work[WIDTH-1:1]};
      cy_q <= bit_c;
      cnt  <= cnt + CW'(1);
      if (last) begin
        result <= {bit_s, work[WIDTH-1:1]};
        carry  <= bit_c;
      end
    end
  end

endmodule
